// File: rtl/hrs_12_to_24.sv
// hrs_12_to_24: registered 12-hour (1..12 + AM/PM) to 24-hour (0..23) converter; optional BCD output via HRS_12_TO_24_BCD_EN
module hrs_12_to_24 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] h12,
  input  logic       pm1,
  output logic       out_valid,
  output logic [4:0] h24,
`ifdef HRS_12_TO_24_BCD_EN
  output logic [7:0] h24_bcd,
`endif
  output logic       err
);
  logic       r_out_valid;
  logic       r_err;
  logic [4:0] r_h24;
  logic       w_legal;
  logic       w_load;
  logic [4:0] w_h24;
  assign w_legal = (h12 != 4'd0) && (h12 <= 4'd12);
  assign w_load  = in_valid && w_legal;
  assign w_h24   = (h12 == 4'd12) ? (pm1 ? 5'd12 : 5'd0)
                                  : ({1'b0, h12} + (pm1 ? 5'd12 : 5'd0));
  // strobe and error flag follow every cycle's in_valid; a reset drops any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_err       <= in_valid && !w_legal;
    end
  end
  // hour register only loads on a legal accepted input, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_h24 <= 5'd0;
    else if (w_load) r_h24 <= w_h24;
  end
`ifdef HRS_12_TO_24_BCD_EN
  logic [7:0] r_h24_bcd;
  logic [3:0] w_tens;
  logic [4:0] w_ones;
  assign w_tens = (w_h24 >= 5'd20) ? 4'd2 : (w_h24 >= 5'd10) ? 4'd1 : 4'd0;
  assign w_ones = (w_h24 >= 5'd20) ? w_h24 - 5'd20 : (w_h24 >= 5'd10) ? w_h24 - 5'd10 : w_h24;
  // BCD copy of the hour, loaded and held exactly like the binary hour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_h24_bcd <= 8'h00;
    else if (w_load) r_h24_bcd <= {w_tens, w_ones[3:0]};
  end
  assign h24_bcd = r_h24_bcd;
`endif
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign h24       = r_h24;
endmodule

// File: tb/tb_hrs_12_to_24.sv
// tb_hrs_12_to_24: self-checking bench for hrs_12_to_24 with a behavioural hour-mapping model
module tb_hrs_12_to_24;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] h12 = 4'd0;
  logic       pm1 = 1'b0;
  logic       out_valid;
  logic       err;
  logic [4:0] h24;
`ifdef HRS_12_TO_24_BCD_EN
  logic [7:0] h24_bcd;
`endif
  int nvec = 0;
  int nerr = 0;
  logic [4:0] held;

  hrs_12_to_24 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .h12(h12), .pm1(pm1),
    .out_valid(out_valid), .h24(h24),
`ifdef HRS_12_TO_24_BCD_EN
    .h24_bcd(h24_bcd),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_h24(input int h, input bit pm);
    return 5'((h % 12) + (pm ? 12 : 0));
  endfunction

  function automatic logic [7:0] ref_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic drive(input int h, input bit pm, input bit v);
    h12 = 4'(h);
    pm1 = pm;
    in_valid = v;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(5, 0, 1);
    @(negedge clk);
    drive(0, 0, 0);
    nvec++;
    if ({out_valid, err, h24} !== {1'b1, 1'b0, 5'd5}) begin
      nerr++;
      $display("FAIL reset_preload: got ov=%b err=%b h24=%0d, want ov=1 err=0 h24=5", out_valid, err, h24);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, err, h24} !== 7'd0) begin
      nerr++;
      $display("FAIL reset_async: got ov=%b err=%b h24=%0d, want all 0", out_valid, err, h24);
    end
`ifdef HRS_12_TO_24_BCD_EN
    nvec++;
    if (h24_bcd !== 8'h00) begin
      nerr++;
      $display("FAIL reset_bcd: got %h, want 00", h24_bcd);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    held = 5'd0;
    repeat (2) begin
      @(negedge clk);
      nvec++;
      if ({out_valid, err, h24} !== 7'd0) begin
        nerr++;
        $display("FAIL reset_idle: got ov=%b err=%b h24=%0d, want all 0", out_valid, err, h24);
      end
    end
  endtask

  task automatic test_boundary();
    int hs[6] = '{12, 1, 11, 12, 1, 11};
    bit ps[6] = '{0, 0, 0, 1, 1, 1};
    int ex[6] = '{0, 1, 11, 12, 13, 23};
    for (int i = 0; i < 6; i++) begin
      drive(hs[i], ps[i], 1);
      @(negedge clk);
      nvec++;
      if ({out_valid, err, h24} !== {1'b1, 1'b0, 5'(ex[i])}) begin
        nerr++;
        $display("FAIL boundary h12=%0d pm=%0d: got ov=%b err=%b h24=%0d, want ov=1 err=0 h24=%0d",
                 hs[i], ps[i], out_valid, err, h24, ex[i]);
      end
      held = 5'(ex[i]);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_sweep();
    int cnt[24];
    for (int i = 0; i < 24; i++) cnt[i] = 0;
    for (int p = 0; p < 2; p++)
      for (int h = 1; h <= 12; h++) begin
        drive(h, p[0], 1);
        @(negedge clk);
        nvec++;
        if ({out_valid, err, h24} !== {1'b1, 1'b0, ref_h24(h, p[0])}) begin
          nerr++;
          $display("FAIL sweep h12=%0d pm=%0d: got ov=%b err=%b h24=%0d, want ov=1 err=0 h24=%0d",
                   h, p, out_valid, err, h24, ref_h24(h, p[0]));
        end
        if (h24 < 24) cnt[h24]++;
        held = ref_h24(h, p[0]);
`ifdef HRS_12_TO_24_BCD_EN
        nvec++;
        if (h24_bcd !== ref_bcd(int'(ref_h24(h, p[0])))) begin
          nerr++;
          $display("FAIL sweep_bcd h12=%0d pm=%0d: got %h, want %h", h, p, h24_bcd, ref_bcd(int'(ref_h24(h, p[0]))));
        end
        if (h == 7 && p == 1) begin
          nvec++;
          if (h24_bcd !== 8'h19) begin
            nerr++;
            $display("FAIL bcd_7pm: got %h, want 19", h24_bcd);
          end
        end
`endif
      end
    drive(0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      nvec++;
      if (cnt[i] != 1) begin
        nerr++;
        $display("FAIL sweep_once h24=%0d: seen %0d times, want 1", i, cnt[i]);
      end
    end
  endtask

  task automatic test_illegal();
    drive(5, 0, 1);
    @(negedge clk);
    nvec++;
    if ({out_valid, err, h24} !== {1'b1, 1'b0, 5'd5}) begin
      nerr++;
      $display("FAIL illegal_setup: got ov=%b err=%b h24=%0d, want ov=1 err=0 h24=5", out_valid, err, h24);
    end
    held = 5'd5;
    drive(0, 1, 1);
    @(negedge clk);
    nvec++;
    if ({out_valid, err, h24} !== {1'b1, 1'b1, 5'd5}) begin
      nerr++;
      $display("FAIL illegal_0pm: got ov=%b err=%b h24=%0d, want ov=1 err=1 h24=5", out_valid, err, h24);
    end
    drive(15, 0, 1);
    @(negedge clk);
    nvec++;
    if ({out_valid, err, h24} !== {1'b1, 1'b1, 5'd5}) begin
      nerr++;
      $display("FAIL illegal_15am: got ov=%b err=%b h24=%0d, want ov=1 err=1 h24=5", out_valid, err, h24);
    end
    drive(13, 1, 0);
    @(negedge clk);
    nvec++;
    if ({out_valid, err, h24} !== {1'b0, 1'b0, 5'd5}) begin
      nerr++;
      $display("FAIL illegal_idle: got ov=%b err=%b h24=%0d, want ov=0 err=0 h24=5", out_valid, err, h24);
    end
  endtask

  task automatic test_gap();
    bit v[3] = '{1, 0, 1};
    int hs[3] = '{3, 6, 9};
    bit ps[3] = '{1, 1, 0};
    int ex[3] = '{15, 15, 9};
    for (int i = 0; i < 3; i++) begin
      drive(hs[i], ps[i], v[i]);
      @(negedge clk);
      nvec++;
      if ({out_valid, err, h24} !== {v[i], 1'b0, 5'(ex[i])}) begin
        nerr++;
        $display("FAIL gap step%0d: got ov=%b err=%b h24=%0d, want ov=%b err=0 h24=%0d",
                 i, out_valid, err, h24, v[i], ex[i]);
      end
    end
    held = 5'd9;
    drive(0, 0, 0);
  endtask

  task automatic test_random();
    int acc = 0;
    int pulses = 0;
    int h;
    bit p, v;
    logic [4:0] e;
    while (acc < 100) begin
      v = ($urandom_range(0, 3) != 0);
      h = $urandom_range(1, 12);
      p = 1'($urandom_range(0, 1));
      drive(h, p, v);
      if (v) begin
        acc++;
        held = ref_h24(h, p);
      end
      e = held;
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
      nvec++;
      if ({out_valid, err, h24} !== {v, 1'b0, e}) begin
        nerr++;
        $display("FAIL random h12=%0d pm=%0d v=%0d: got ov=%b err=%b h24=%0d, want ov=%b err=0 h24=%0d",
                 h, p, v, out_valid, err, h24, v, e);
      end
`ifdef HRS_12_TO_24_BCD_EN
      nvec++;
      if (h24_bcd !== ref_bcd(int'(e))) begin
        nerr++;
        $display("FAIL random_bcd: got %h, want %h", h24_bcd, ref_bcd(int'(e)));
      end
`endif
    end
    drive(0, 0, 0);
    @(negedge clk);
    nvec++;
    if (pulses != 100) begin
      nerr++;
      $display("FAIL random_pulses: got %0d, want 100", pulses);
    end
  endtask

  task automatic test_reset_midflight();
    drive(11, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, err, h24} !== 7'd0) begin
      nerr++;
      $display("FAIL midflight_assert: got ov=%b err=%b h24=%0d, want all 0", out_valid, err, h24);
    end
    @(negedge clk);
    drive(0, 0, 0);
    rst_n = 1'b1;
    held = 5'd0;
    repeat (2) begin
      @(negedge clk);
      nvec++;
      if ({out_valid, err, h24} !== 7'd0) begin
        nerr++;
        $display("FAIL midflight_release: got ov=%b err=%b h24=%0d, want all 0", out_valid, err, h24);
      end
    end
  endtask

  initial begin
    held = 5'd0;
    test_reset();
    test_boundary();
    test_sweep();
    test_illegal();
    test_gap();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
